// File: rtl/bcd_timer_ctrl.sv
// bcd_timer_ctrl: run controller and tick prescaler for a BCD digit chain.
// Optional lap capture register is built when BCD_TIMER_LAP_EN is defined.
module bcd_timer_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  limit_en,
  input  logic [4*DIGITS-1:0]   limit,
  input  logic [4*DIGITS-1:0]   digits,
  input  logic                  lap_req,
  output logic                  count_en,
  output logic                  digit_clr,
  output logic [1:0]            state,
  output logic                  alarm,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   lap,
  output logic                  lap_valid
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_PAUSED = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [PW-1:0] pre;
  logic [1:0]    state_nxt;
  logic          all_nines;
  logic          match;
  logic          run;
  logic          tick;
  logic          alarm_set;
  logic          ovf_set;
  logic          pre_zero;
  logic          pre_adv;

  // Non-BCD nibbles simply fail the compare and count as not-9.
  always_comb begin
    all_nines = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (digits[4*i +: 4] != 4'd9) all_nines = 1'b0;
    end
  end

  assign match = limit_en && (digits == limit);
  assign run   = (state == S_RUN);
  assign tick  = run && (pre == PMAX);

  assign count_en = reset && tick && !match
                  && !all_nines && !stop && !clear;

  always_comb begin
    state_nxt = state;
    alarm_set = 1'b0;
    ovf_set   = 1'b0;
    if (clear) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE, S_PAUSED: begin
          if (start && !stop) state_nxt = S_RUN;
        end
        S_RUN: begin
          if (stop) begin
            state_nxt = S_PAUSED;
          end else if (match) begin
            state_nxt = S_DONE;
            alarm_set = 1'b1;
          end else if (tick && all_nines) begin
            state_nxt = S_DONE;
            ovf_set   = 1'b1;
          end
        end
        default: begin
          state_nxt = state;
        end
      endcase
    end
  end

  // A stop cycle holds the prescaler so a resume finishes the partial period.
  assign pre_zero = clear
                  || (state == S_IDLE && start && !stop);
  assign pre_adv  = run && !stop;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      pre       <= '0;
      alarm     <= 1'b0;
      overflow  <= 1'b0;
      digit_clr <= 1'b1;
    end else begin
      state     <= state_nxt;
      digit_clr <= clear;
      if (clear)          alarm <= 1'b0;
      else if (alarm_set) alarm <= 1'b1;
      if (clear)        overflow <= 1'b0;
      else if (ovf_set) overflow <= 1'b1;
      if (pre_zero) begin
        pre <= '0;
      end else if (pre_adv) begin
        pre <= (pre == PMAX) ? '0 : pre + PW'(1);
      end
    end
  end

`ifdef BCD_TIMER_LAP_EN
  logic lap_ok;

  assign lap_ok = lap_req
                && (state == S_RUN || state == S_PAUSED);

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      lap       <= '0;
      lap_valid <= 1'b0;
    end else if (lap_ok) begin
      lap       <= digits;
      lap_valid <= 1'b1;
    end
  end
`else
  logic unused_lap_req;

  assign unused_lap_req = lap_req;
  assign lap            = '0;
  assign lap_valid      = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// tb_bcd_timer_ctrl: directed bench with a cycle-level reference model.
// Models the BCD chain as an integer and checks every output each cycle.
module tb_bcd_timer_ctrl;

  localparam int P = 4;
`ifdef BCD_TIMER_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, start, stop, clear;
  logic       limit_en, lap_req;
  logic [7:0] limit, chain, lap;
  logic       count_en, digit_clr;
  logic       alarm, overflow, lap_valid;
  logic [1:0] state;
  logic       preload;
  logic [7:0] pval;

  int n_checks = 0;
  int n_fail   = 0;
  int ce_count = 0;
  int c0;

  always #5 clk = ~clk;

  bcd_timer_ctrl #(.DIGITS(2), .PRESCALE(P)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .clear     (clear),
    .limit_en  (limit_en),
    .limit     (limit),
    .digits    (chain),
    .lap_req   (lap_req),
    .count_en  (count_en),
    .digit_clr (digit_clr),
    .state     (state),
    .alarm     (alarm),
    .overflow  (overflow),
    .lap       (lap),
    .lap_valid (lap_valid)
  );

  function automatic int from_bcd(logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] to_bcd(int v);
    logic [7:0] r;
    r[7:4] = 4'((v / 10) % 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  // The counter chain the controller drives.
  always @(posedge clk) begin
    if (digit_clr === 1'b1)    chain <= 8'h00;
    else if (preload)          chain <= pval;
    else if (count_en === 1'b1)
      chain <= to_bcd((from_bcd(chain) + 1) % 100);
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: state 0..3, RUN cycles into period, value as int.
  int m_st = 0, m_ph = 0, m_val = 0, m_lap = 0, nval;
  bit m_alarm = 0, m_ovf = 0, m_lv = 0;
  bit m_clr = 1, known = 0;

  always @(negedge clk) begin
    bit e_ce, match, nines, tick;
    match = limit_en && (m_val == from_bcd(limit));
    nines = (m_val == 99);
    tick  = (m_st == 1) && (m_ph == P - 1);
    e_ce  = reset && tick && !match && !nines && !stop && !clear;
    if (count_en === 1'b1) ce_count++;
    if (known) begin
      chk("count_en", count_en, e_ce);
      chk("digit_clr", digit_clr, m_clr);
      chk("state", state, m_st);
      chk("alarm", alarm, m_alarm);
      chk("overflow", overflow, m_ovf);
      chk("lap", lap, to_bcd(m_lap));
      chk("lap_valid", lap_valid, m_lv);
      chk("chain", chain, to_bcd(m_val));
    end
    if (m_clr)        nval = 0;
    else if (preload) nval = from_bcd(pval);
    else if (e_ce)    nval = m_val + 1;
    else              nval = m_val;
    if (!reset) begin
      m_st = 0; m_ph = 0; m_alarm = 0; m_ovf = 0;
      m_lap = 0; m_lv = 0; m_clr = 1; known = 1;
    end else begin
      m_clr = clear;
      if (clear) begin
        m_st = 0; m_ph = 0; m_alarm = 0;
        m_ovf = 0; m_lap = 0; m_lv = 0;
      end else begin
        if (LAP_EN && lap_req && (m_st == 1 || m_st == 2)) begin
          m_lap = m_val;
          m_lv  = 1;
        end
        case (m_st)
          0: if (start && !stop) begin m_st = 1; m_ph = 0; end
          1: begin
            if (stop) m_st = 2;
            else begin
              m_ph = (m_ph + 1) % P;
              if (match) begin
                m_st = 3; m_alarm = 1;
              end else if (tick && nines) begin
                m_st = 3; m_ovf = 1;
              end
            end
          end
          2: if (start && !stop) m_st = 1;
          default: ;
        endcase
      end
    end
    m_val = nval;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; step(1); start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; step(1); clear = 1'b0; step(1);
  endtask

  initial begin
    logic [7:0] exp_lap;
    reset = 0; start = 0; stop = 0; clear = 0;
    limit_en = 0; limit = 8'h00; lap_req = 0;
    preload = 0; pval = 8'h00;
    step(3);
    reset = 1'b1;
    chk("clr_after_release", digit_clr, 1'b1);
    chk("state_after_reset", state, 2'd0);
    step(1);
    chk("clr_deassert", digit_clr, 1'b0);
    c0 = ce_count;
    step(20);
    chk("idle_no_ce", ce_count - c0, 0);

    pulse_start();
    c0 = ce_count;
    step(3);
    chk("first_tick_cycle4", count_en, 1'b1);
    step(37);
    chk("run40_ticks", ce_count - c0, 10);
    chk("run40_chain", chain, 8'h10);
    do_clear();

    pulse_start();
    step(6);
    stop = 1'b1; step(1); stop = 1'b0;
    c0 = ce_count;
    step(9);
    chk("paused_no_ce", ce_count - c0, 0);
    chk("paused_state", state, 2'd2);
    chk("paused_chain", chain, 8'h01);
    pulse_start();
    chk("resume_cyc1", count_en, 1'b0);
    step(1);
    chk("resume_cyc2", count_en, 1'b1);
    do_clear();

    limit = 8'h07; limit_en = 1'b1;
    pulse_start();
    step(40);
    chk("limit_chain", chain, 8'h07);
    chk("limit_state", state, 2'd3);
    chk("limit_alarm", alarm, 1'b1);
    c0 = ce_count;
    step(5);
    chk("limit_no_ce", ce_count - c0, 0);
    clear = 1'b1; step(1); clear = 1'b0;
    chk("clear_pulse", digit_clr, 1'b1);
    chk("clear_state", state, 2'd0);
    chk("clear_alarm", alarm, 1'b0);
    step(1);
    chk("clear_pulse_end", digit_clr, 1'b0);
    limit_en = 1'b0;

    preload = 1'b1; pval = 8'h99; step(1); preload = 1'b0;
    chk("preload_99", chain, 8'h99);
    pulse_start();
    c0 = ce_count;
    step(10);
    chk("ovf_no_ce", ce_count - c0, 0);
    chk("ovf_state", state, 2'd3);
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_chain", chain, 8'h99);
    do_clear();

    exp_lap = LAP_EN ? 8'h23 : 8'h00;
    pulse_start();
    step(92);
    chk("lap_chain_23", chain, 8'h23);
    lap_req = 1'b1; step(1); lap_req = 1'b0;
    chk("lap_value", lap, exp_lap);
    chk("lap_valid", lap_valid, LAP_EN);
    step(20);
    chk("lap_held", lap, exp_lap);
    chk("lap_run_chain", chain, 8'h28);
    do_clear();
    chk("lap_cleared", lap, 8'h00);
    chk("lap_valid_cleared", lap_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
